// File: rtl/aes_round_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : aes_round_controller                                     |
// | Brief    : Sequences the AES-128 initial key add and cipher rounds   |
// |            around a shared combinational round datapath.            |
// | Revision : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module aes_round_controller #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    output logic [3:0]   round_idx,
    input  logic [127:0] round_key,
    input  logic         key_valid,
    output logic [127:0] dp_state,
    output logic         dp_bypass_mix,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_data;
    logic [127:0] w_data_nxt;
    logic [3:0]   r_round_idx;
    logic [3:0]   w_round_idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_round_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_round_idx <= w_round_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_round_idx_nxt = r_round_idx;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && key_valid) begin
                    w_data_nxt      = plaintext ^ round_key;
                    w_round_idx_nxt = 4'd1;
                    w_state_nxt     = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // A missing key simply freezes the round; no partial update.
                if (key_valid) begin
                    w_data_nxt = dp_result;
                    if (r_round_idx == c_last_round) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_round_idx_nxt = r_round_idx + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_round_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_round_idx_nxt = '0;
            end
        endcase
    end

    assign in_ready      = (r_state == ST_IDLE);
    assign out_valid     = (r_state == ST_DONE);
    assign busy          = (r_state != ST_IDLE);
    assign dp_bypass_mix = (r_state == ST_ROUND) && (r_round_idx == c_last_round);
    assign round_idx     = r_round_idx;
    assign dp_state      = r_data;
    assign ciphertext    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_aes_round_controller                                  |
// | Brief    : Self-checking bench with an AES-128 model, key schedule   |
// |            and round datapath for aes_round_controller.             |
// | Revision : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_aes_round_controller;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] FIPS_C1  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         key_valid;
    logic [127:0] dp_state;
    logic         dp_bypass_mix;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    logic [127:0] rk_q [0:10];
    int n_tests;
    int n_fail;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] c1;
        logic [127:0] r1;
        int           stall_round;
        int           stall_len;
        int           bp;
    } vec_t;

    vec_t vecs [6];

    aes_round_controller #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .round_idx(round_idx), .round_key(round_key),
        .key_valid(key_valid), .dp_state(dp_state), .dp_bypass_mix(dp_bypass_mix),
        .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES-128 reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  sq;
        logic [7:0]  inv;
        logic [15:0] d;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gm(sq, sq);
            inv = gm(inv, sq);
        end
        d = {inv, inv};
        return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   t0, t1, t2, t3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
                b[4*c]   = xt(t0) ^ xt(t1) ^ t1 ^ t2 ^ t3;
                b[4*c+1] = t0 ^ xt(t1) ^ xt(t2) ^ t2 ^ t3;
                b[4*c+2] = t0 ^ t1 ^ xt(t2) ^ xt(t3) ^ t3;
                b[4*c+3] = xt(t0) ^ t0 ^ t1 ^ t2 ^ xt(t3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] key_of(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        s = pt ^ key_of(key, 0);
        for (int r = 1; r <= 10; r++) s = aes_round(s, key_of(key, r), r == 10);
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Key schedule and round datapath seen by the controller.
    assign round_key = (round_idx <= 4'd10) ? rk_q[round_idx] : '0;
    assign dp_result = aes_round(dp_state, round_key, dp_bypass_mix);

    // ---------------- bench helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        for (int r = 0; r <= 10; r++) rk_q[r] = key_of(key, r);
    endtask

    task automatic run_block(input vec_t v);
        logic [127:0] m;
        logic [127:0] ps;
        logic [3:0]   pi;
        logic         kv;
        int           cyc;
        int           stalled;
        load_key(v.key);
        plaintext = v.pt;
        in_valid  = 1'b1;
        key_valid = 1'b0;
        out_ready = 1'b0;
        step();
        chk("no_accept_without_key", busy, 1'b0);
        chk("in_ready_not_gated", in_ready, 1'b1);
        key_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        plaintext = rand128();
        cyc       = 1;
        stalled   = 0;
        m         = v.pt ^ rk_q[0];
        if (v.c1 !== '0) chk("cycle1_state", dp_state, v.c1);
        while (!out_valid && cyc < 60) begin
            chk("dp_state", dp_state, m);
            chk("bypass_mix", dp_bypass_mix, round_idx == NR);
            if (cyc == 2 && v.r1 !== '0) chk("after_round1", dp_state, v.r1);
            kv = !(round_idx == v.stall_round && stalled < v.stall_len);
            if (!kv) stalled++;
            key_valid = kv;
            pi = round_idx;
            ps = dp_state;
            step();
            cyc++;
            if (!kv) begin
                chk("stall_idx_frozen", round_idx, pi);
                chk("stall_state_frozen", dp_state, ps);
            end else begin
                m = aes_round(m, rk_q[pi], pi == NR);
                if (out_valid) chk("idx_hold_last", round_idx, NR);
                else           chk("idx_step", round_idx, pi + 4'd1);
            end
        end
        key_valid = 1'b1;
        chk("latency", cyc, NR + 1 + v.stall_len);
        chk("out_valid", out_valid, 1'b1);
        chk("ciphertext", ciphertext, v.ct);
        chk("done_busy", busy, 1'b1);
        chk("done_in_ready", in_ready, 1'b0);
        chk("done_bypass", dp_bypass_mix, 1'b0);
        for (int i = 0; i < v.bp; i++) begin
            in_valid = 1'b1;
            step();
            chk("bp_ciphertext", ciphertext, v.ct);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_in_ready", in_ready, 1'b1);
        chk("post_hs_out_valid", out_valid, 1'b0);
        chk("post_hs_idx", round_idx, 4'd0);
        chk("post_hs_busy", busy, 1'b0);
    endtask

    task automatic back_to_back();
        logic [127:0] pts [2];
        logic [127:0] key;
        logic [127:0] cts [$];
        int           acc [$];
        int           cyc;
        logic         acc_now;
        pts[0] = rand128();
        pts[1] = rand128();
        key    = rand128();
        load_key(key);
        out_ready = 1'b1;
        key_valid = 1'b1;
        in_valid  = 1'b1;
        plaintext = pts[0];
        cyc = 0;
        while ((acc.size() < 2 || cts.size() < 2) && cyc < 80) begin
            acc_now = in_ready && in_valid;
            if (out_valid) cts.push_back(ciphertext);
            step();
            cyc++;
            if (acc_now) begin
                acc.push_back(cyc - 1);
                if (acc.size() == 1) plaintext = pts[1];
                else                 in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        chk("b2b_accepts", acc.size(), 2);
        chk("b2b_outputs", cts.size(), 2);
        if (acc.size() == 2) chk("b2b_spacing", acc[1] - acc[0], 12);
        if (cts.size() == 2) begin
            chk("b2b_ct0", cts[0], aes_encrypt(pts[0], key));
            chk("b2b_ct1", cts[1], aes_encrypt(pts[1], key));
        end
    endtask

    task automatic reset_mid_round();
        int cyc;
        load_key(FIPS_KEY);
        plaintext = FIPS_PT;
        key_valid = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (round_idx != 4'd5 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("pre_reset_idx", round_idx, 4'd5);
        // Handshake inputs stay asserted to show reset wins over an accept.
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_idx", round_idx, 4'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ciphertext", ciphertext, 128'h0);
        chk("rst_bypass", dp_bypass_mix, 1'b0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        key_valid = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        load_key(FIPS_KEY);
        step();
        step();
        rst = 1'b0;
        chk("init_in_ready", in_ready, 1'b1);
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_busy", busy, 1'b0);
        chk("init_idx", round_idx, 4'd0);
        chk("init_ciphertext", ciphertext, 128'h0);

        vecs[0] = '{pt: FIPS_PT, key: FIPS_KEY, ct: FIPS_CT, c1: FIPS_C1, r1: FIPS_R1,
                    stall_round: 1, stall_len: 0, bp: 0};
        vecs[1] = '{pt: FIPS_PT, key: FIPS_KEY, ct: FIPS_CT, c1: FIPS_C1, r1: FIPS_R1,
                    stall_round: 4, stall_len: 3, bp: 5};
        for (int i = 2; i < 6; i++) begin
            vecs[i].pt          = rand128();
            vecs[i].key         = rand128();
            vecs[i].ct          = aes_encrypt(vecs[i].pt, vecs[i].key);
            vecs[i].c1          = '0;
            vecs[i].r1          = '0;
            vecs[i].stall_round = int'($urandom_range(1, NR));
            vecs[i].stall_len   = int'($urandom_range(0, 3));
            vecs[i].bp          = int'($urandom_range(0, 3));
        end
        vecs[5].stall_round = NR;
        vecs[5].stall_len   = 2;

        for (int i = 0; i < 6; i++) run_block(vecs[i]);
        back_to_back();
        reset_mid_round();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_controller.md
# aes_round_controller

Sequencing controller for the AES-128 encryption datapath. It accepts a 128-bit plaintext block over a valid/ready handshake and holds the working state register. It steps the shared combinational round datapath (subBytes, shiftRows, mixColumns, addRoundKey) and the external key schedule through the initial key addition and NUM_ROUNDS rounds, then presents the ciphertext over a second valid/ready handshake. It sits between the top-level I/O wrapper and the round datapath and makes sure mixColumns is bypassed on the final round.

## Interface
- NUM_ROUNDS, default 10: number of cipher rounds after the initial addRoundKey. Legal range 1..15.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  plaintext offered
- in_ready  output  1  controller can accept plaintext
- plaintext  input  128  input block, byte 0 in bits [127:120]
- round_idx  output  4  round whose key the key schedule must present on round_key
- round_key  input  128  round key for round_idx, from key schedule
- key_valid  input  1  round_key is valid for the current round_idx
- dp_state  output  128  working state driven into the round datapath
- dp_bypass_mix  output  1  high when round_idx == NUM_ROUNDS; datapath skips mixColumns
- dp_result  input  128  combinational round output: addRoundKey(mix(shift(sub(dp_state))), round_key)
- out_valid  output  1  ciphertext available
- out_ready  input  1  downstream accepts ciphertext
- ciphertext  output  128  equals dp_state while out_valid is high
- busy  output  1  high in ROUND and DONE

## Operation
- State machine with three states:
  - IDLE: in_ready = 1, round_idx = 0.
    - Accept when in_valid && key_valid. On accept: state_reg <= plaintext ^ round_key, round_idx <= 1, next state ROUND.
    - in_valid while key_valid = 0: no accept, stay in IDLE. in_ready stays 1 and is not gated by key_valid; acceptance requires both.
  - ROUND: in_ready = 0.
    - If key_valid: state_reg <= dp_result.
      - If round_idx == NUM_ROUNDS, next state DONE and round_idx holds.
      - Otherwise round_idx <= round_idx + 1.
    - If key_valid = 0: stall, with state_reg and round_idx unchanged.
  - DONE: out_valid = 1, ciphertext = state_reg.
    - On out_ready: next state IDLE, round_idx <= 0. state_reg holds until the next accept.
    - in_ready = 0 in DONE, so the earliest next accept is the cycle after the out handshake.
- dp_state always equals state_reg. Outside ROUND, dp_bypass_mix is 0 and dp_result is ignored.
- round_idx never exceeds NUM_ROUNDS, so there is no wrap-around. A 4-bit counter is sufficient for NUM_ROUNDS ≤ 15.
- Once a block is accepted it cannot be aborted except by rst.
- rst (synchronous, any state):
  - State goes to IDLE, state_reg to 0, round_idx to 0.
  - Outputs after the reset edge: out_valid 0, in_ready 1, busy 0, dp_bypass_mix 0, ciphertext 0.
  - In-flight data is discarded.
  - rst takes priority over every handshake in the same cycle.

## Timing
- Cycle 0 is the cycle in which in_valid && in_ready && key_valid are sampled high.
- With key_valid held high, out_valid rises in cycle NUM_ROUNDS+1. That is cycle 11 for the default.
- Each cycle with key_valid low during ROUND adds exactly one cycle of latency.
- out_valid and ciphertext stay stable until they are consumed by out_ready; there is no combinational path from out_ready to out_valid.
- Throughput with the default NUM_ROUNDS and no stalls is one block per 12 cycles when out_ready is held high: accept, 10 rounds, DONE.
- round_idx changes only on clock edges. The key schedule has one full cycle to present round_key and key_valid for the new index.
- All outputs are registered or decoded from registered state only.

## Test plan
- Reset values: assert rst for 2 cycles mid-ROUND at round_idx = 5 -> next cycle: IDLE, round_idx 0, out_valid 0, in_ready 1, busy 0, ciphertext 0.
- FIPS-197 vector, with the bench providing a golden key schedule and datapath model:
  - Stimulus: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, key_valid held high.
  - Required response: ciphertext 3925841d02dc09fbdc118597196a0b32 with out_valid rising exactly in cycle 11.
  - Required response: dp_bypass_mix high only while round_idx = 10.
- Round sequencing: same vector, monitor dp_state.
  - Cycle 1 dp_state = 193de3bea0f4e22b9ac68d2ae9f84808.
  - dp_state after round 1 = a49c7ff2689f352b6b5bea43026a5049.
  - round_idx steps 0,1,…,10 with no skips.
- Key stall: drop key_valid for 3 cycles at round_idx = 4 -> round_idx and dp_state frozen for those cycles, out_valid delayed to cycle 14, ciphertext unchanged from the FIPS value.
- Output backpressure:
  - Stimulus: out_ready low for 5 cycles after out_valid rises, with in_valid held high.
  - Required response: ciphertext stable, in_ready 0 throughout.
  - After the out handshake: IDLE and in_ready 1 the next cycle, second block accepted, no overlap.
- Back-to-back blocks with NUM_ROUNDS = 10 and out_ready tied high -> two accepts exactly 12 cycles apart, both ciphertexts correct against the model.
